// File: rtl/saturn_pad_pkg.sv
// Shared definitions for the Saturn controller-port keyboard transmitter.
//   - state_t   : transmitter FSM states
//   - nibble constants used in the 12-nibble keyboard packet
//   - PKT_LEN   : number of nibbles in one packet
package saturn_pad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READY,
    WAIT_TR,
    ACK,
    ABORT
  } state_t;

  localparam logic [3:0] ID0    = 4'h3;
  localparam logic [3:0] ID1    = 4'h4;
  localparam logic [3:0] MK     = 4'hE;
  localparam logic [3:0] BRK    = 4'h7;
  localparam logic [3:0] NONE   = 4'h6;
  localparam logic [3:0] TAIL0  = 4'h0;
  localparam logic [3:0] TAIL1  = 4'h1;
  localparam logic [3:0] IDLE_D = 4'h1;

  localparam int PKT_LEN = 12;

endpackage

// File: rtl/saturn_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset to 1, matching the idle level of the TH/TR lines.
//   clk     : system clock
//   reset_n : synchronous reset, active-low
//   d       : asynchronous input
//   q       : synchronised output
module saturn_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_p0 <= 1'b1;
      q       <= 1'b1;
    end else begin
      meta_p0 <= d;
      // second stage: metastability-settled copy
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/saturn_kbd_port.sv
// Saturn keyboard packet transmitter (peripheral side of the TH/TR/TL
// handshake). Sends a 12-nibble packet on d_out, one nibble per TR edge,
// and pops the pending key event once its scancode has been acknowledged.
//   clk, reset_n        : clock, synchronous active-low reset
//   enable              : keyboard mode selected; low holds the port idle
//   nib_*               : live button nibbles (active-low)
//   led                 : {scroll,num,caps} lock LEDs
//   ev_valid/make/sc    : single-entry key event from the PS/2 front end
//   ev_pop              : one-cycle pulse consuming the event
//   th_in, tr_in        : asynchronous select / request from the SMPC
//   tl_out, d_out       : acknowledge and data nibble
module saturn_kbd_port
  import saturn_pad_pkg::*;
#(
  parameter int ACK_DLY = 8,
  parameter int TMO_CYC = 65535,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [3:0] nib_dpad,
  input  logic [3:0] nib_start_abc,
  input  logic [3:0] nib_rxyz,
  input  logic [3:0] nib_lxxx,
  input  logic [2:0] led,
  input  logic       ev_valid,
  input  logic       ev_make,
  input  logic [7:0] ev_sc,
  output logic       ev_pop,
  input  logic       th_in,
  input  logic       tr_in,
  output logic       tl_out,
  output logic [3:0] d_out
);

  localparam logic [CNT_W-1:0] ACK_LOAD = CNT_W'(ACK_DLY - 1);
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TMO_CYC - 1);
  localparam logic [3:0]       IDX_END  = 4'(PKT_LEN);

  logic             th_s, tr_s;
  logic             th_prev, tr_prev;
  logic             th_fall, th_rise, tr_edge;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       idx;
  logic             snap_valid, snap_make;
  logic [7:0]       snap_sc;

  saturn_sync2 u_sync_th (.clk(clk), .reset_n(reset_n), .d(th_in), .q(th_s));
  saturn_sync2 u_sync_tr (.clk(clk), .reset_n(reset_n), .d(tr_in), .q(tr_s));

  assign th_fall = th_prev & ~th_s;
  assign th_rise = ~th_prev & th_s;
  assign tr_edge = tr_prev ^ tr_s;

  // Buttons and LEDs are read live; event fields only from the snapshot.
  function automatic logic [3:0] nibble_at(input logic [3:0] i);
    logic [3:0] n;
    n = TAIL0;
    case (i)
      4'd0:    n = ID0;
      4'd1:    n = ID1;
      4'd2:    n = nib_dpad;
      4'd3:    n = nib_start_abc;
      4'd4:    n = nib_rxyz;
      4'd5:    n = nib_lxxx;
      4'd6:    n = {1'b0, led[0], led[1], led[2]};
      4'd7:    n = snap_valid ? (snap_make ? MK : BRK) : NONE;
      4'd8:    n = snap_sc[7:4];
      4'd9:    n = snap_sc[3:0];
      4'd10:   n = TAIL0;
      4'd11:   n = TAIL1;
      default: n = TAIL0;
    endcase
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      tl_out     <= 1'b1;
      d_out      <= IDLE_D;
      ev_pop     <= 1'b0;
      idx        <= 4'd0;
      cnt        <= '0;
      th_prev    <= 1'b1;
      tr_prev    <= 1'b1;
      snap_valid <= 1'b0;
      snap_make  <= 1'b0;
      snap_sc    <= 8'h00;
    end else begin
      th_prev <= th_s;
      tr_prev <= tr_s;
      ev_pop  <= 1'b0;
      if (!enable) begin
        state  <= IDLE;
        tl_out <= 1'b1;
        d_out  <= IDLE_D;
        idx    <= 4'd0;
        cnt    <= '0;
      end else begin
        // counter stops at zero rather than wrapping
        if (cnt != '0) cnt <= cnt - 1'b1;
        case (state)
          IDLE: begin
            tl_out <= 1'b1;
            d_out  <= IDLE_D;
            if (th_fall) begin
              snap_valid <= ev_valid;
              snap_make  <= ev_make;
              snap_sc    <= ev_valid ? ev_sc : 8'h00;
              cnt        <= ACK_LOAD;
              state      <= READY;
            end
          end
          READY: begin
            if (cnt == '0) begin
              tl_out <= 1'b0;
              idx    <= 4'd0;
              cnt    <= TMO_LOAD;
              state  <= WAIT_TR;
            end
          end
          WAIT_TR: begin
            if (tr_edge) begin
              d_out <= nibble_at(idx);
              cnt   <= ACK_LOAD;
              state <= ACK;
            end else if (cnt == '0) begin
              tl_out <= 1'b1;
              d_out  <= IDLE_D;
              state  <= ABORT;
            end
          end
          ACK: begin
            // TR edges seen here are deliberately dropped
            if (cnt == '0) begin
              tl_out <= ~tl_out;
              if (idx < IDX_END) idx <= idx + 4'd1;
              if (idx == 4'd9 && snap_valid) ev_pop <= 1'b1;
              cnt    <= TMO_LOAD;
              state  <= WAIT_TR;
            end
          end
          ABORT: begin
            tl_out <= 1'b1;
            d_out  <= IDLE_D;
            if (th_s) begin
              cnt   <= '0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
        // Host deselect overrides everything except a pop already issued
        // this cycle, so a scancode acked at the deselect edge is consumed.
        if (th_rise) begin
          state  <= IDLE;
          tl_out <= 1'b1;
          d_out  <= IDLE_D;
          idx    <= 4'd0;
          cnt    <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_saturn_kbd_port.sv
module tb_saturn_kbd_port;

  localparam int ACK_DLY = 4;
  localparam int TMO_CYC = 100;
  localparam int CNT_W   = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] nib_dpad = 4'hF;
  logic [3:0] nib_start_abc = 4'hF;
  logic [3:0] nib_rxyz = 4'hF;
  logic [3:0] nib_lxxx = 4'h8;
  logic [2:0] led = 3'b000;
  logic       ev_valid = 1'b0;
  logic       ev_make = 1'b0;
  logic [7:0] ev_sc = 8'h00;
  logic       ev_pop;
  logic       th_in = 1'b1;
  logic       tr_in = 1'b1;
  logic       tl_out;
  logic [3:0] d_out;

  int n_chk = 0;
  int n_err = 0;
  int pop_cnt = 0;
  int p0;

  // bench-side copy of the event at the moment TH is lowered
  logic       s_v, s_m;
  logic [7:0] s_sc;

  saturn_kbd_port #(.ACK_DLY(ACK_DLY), .TMO_CYC(TMO_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .nib_dpad(nib_dpad), .nib_start_abc(nib_start_abc),
    .nib_rxyz(nib_rxyz), .nib_lxxx(nib_lxxx), .led(led),
    .ev_valid(ev_valid), .ev_make(ev_make), .ev_sc(ev_sc), .ev_pop(ev_pop),
    .th_in(th_in), .tr_in(tr_in), .tl_out(tl_out), .d_out(d_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ev_pop === 1'b1) pop_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tl(input logic want, input int bound, input string tag);
    int k;
    k = 0;
    while (tl_out !== want && k < bound) begin
      step(1);
      k++;
    end
    chk(tag, {31'd0, tl_out}, {31'd0, want});
  endtask

  // Packet content from the keyboard packet table.
  function automatic logic [3:0] model_nib(input int i);
    logic [3:0] n;
    if      (i == 0)  n = 4'h3;
    else if (i == 1)  n = 4'h4;
    else if (i == 2)  n = nib_dpad;
    else if (i == 3)  n = nib_start_abc;
    else if (i == 4)  n = nib_rxyz;
    else if (i == 5)  n = nib_lxxx;
    else if (i == 6)  n = {1'b0, led[0], led[1], led[2]};
    else if (i == 7)  n = !s_v ? 4'h6 : (s_m ? 4'hE : 4'h7);
    else if (i == 8)  n = s_v ? s_sc[7:4] : 4'h0;
    else if (i == 9)  n = s_v ? s_sc[3:0] : 4'h0;
    else if (i == 11) n = 4'h1;
    else              n = 4'h0;
    return n;
  endfunction

  // Select, clock n nibbles, deselect; checks every nibble, every TL
  // toggle, idle recovery and the pop count for the packet.
  task automatic run_packet(input int n, input bit rnd, input string nm);
    logic [3:0] e;
    logic       tv;
    s_v = ev_valid; s_m = ev_make; s_sc = ev_sc;
    p0 = pop_cnt;
    th_in = 1'b0;
    wait_tl(1'b0, ACK_DLY + 6, {nm, "_tl_low"});
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        nib_dpad      = 4'($urandom);
        nib_start_abc = 4'($urandom);
        nib_rxyz      = 4'($urandom);
        nib_lxxx      = {1'($urandom), 3'b000};
        led           = 3'($urandom);
      end
      e  = model_nib(i);
      tv = tl_out;
      tr_in = ~tr_in;
      step(3);
      chk($sformatf("%s_nib%0d", nm, i), {28'd0, d_out}, {28'd0, e});
      chk($sformatf("%s_tl_hold%0d", nm, i), {31'd0, tl_out}, {31'd0, tv});
      wait_tl(~tv, ACK_DLY + 1, $sformatf("%s_tl_tog%0d", nm, i));
    end
    th_in = 1'b1;
    step(3);
    chk({nm, "_idle_tl"}, {31'd0, tl_out}, 32'd1);
    chk({nm, "_idle_d"}, {28'd0, d_out}, 32'h1);
    chk({nm, "_pops"}, pop_cnt - p0, (s_v && n >= 10) ? 32'd1 : 32'd0);
    if (pop_cnt != p0) ev_valid = 1'b0;
    step(2);
  endtask

  initial begin
    // reset state
    step(3);
    chk("rst_tl", {31'd0, tl_out}, 32'd1);
    chk("rst_d", {28'd0, d_out}, 32'h1);
    chk("rst_pop", {31'd0, ev_pop}, 32'd0);
    reset_n = 1'b1;
    enable  = 1'b1;
    step(4);

    // no event, buttons released, LEDs off; one extra edge past the end
    run_packet(13, 1'b0, "noev");

    // make 1C with caps
    led = 3'b001; ev_valid = 1'b1; ev_make = 1'b1; ev_sc = 8'h1C;
    run_packet(12, 1'b0, "make");

    // break 86 with Up held
    led = 3'b000; nib_dpad = 4'hE;
    ev_valid = 1'b1; ev_make = 1'b0; ev_sc = 8'h86;
    run_packet(12, 1'b0, "brk");
    nib_dpad = 4'hF;

    // deselect after nibble 5: no pop, event resent next packet
    ev_valid = 1'b1; ev_make = 1'b1; ev_sc = 8'h5A;
    run_packet(6, 1'b0, "early");
    chk("early_ev_kept", {31'd0, ev_valid}, 32'd1);
    run_packet(12, 1'b0, "resend");

    // timeout with no TR edges
    th_in = 1'b0;
    wait_tl(1'b0, ACK_DLY + 6, "tmo_tl_low");
    step(TMO_CYC - 2);
    chk("tmo_before", {31'd0, tl_out}, 32'd0);
    step(3);
    chk("tmo_abort_tl", {31'd0, tl_out}, 32'd1);
    chk("tmo_abort_d", {28'd0, d_out}, 32'h1);
    th_in = 1'b1;
    step(4);
    run_packet(12, 1'b0, "after_tmo");

    // reset mid-packet
    ev_valid = 1'b1; ev_make = 1'b0; ev_sc = 8'h33;
    p0 = pop_cnt;
    th_in = 1'b0;
    wait_tl(1'b0, ACK_DLY + 6, "rstm_tl_low");
    tr_in = ~tr_in;
    step(3);
    chk("rstm_nib0", {28'd0, d_out}, 32'h3);
    reset_n = 1'b0;
    th_in   = 1'b1;
    step(1);
    chk("rstm_tl", {31'd0, tl_out}, 32'd1);
    chk("rstm_d", {28'd0, d_out}, 32'h1);
    reset_n = 1'b1;
    step(4);
    chk("rstm_pops", pop_cnt - p0, 32'd0);

    // enable low mid-packet
    p0 = pop_cnt;
    th_in = 1'b0;
    wait_tl(1'b0, ACK_DLY + 6, "enm_tl_low");
    for (int i = 0; i < 4; i++) begin
      tr_in = ~tr_in;
      step(3 + ACK_DLY);
    end
    chk("enm_nib3", {28'd0, d_out}, {28'd0, nib_start_abc});
    enable = 1'b0;
    step(1);
    chk("enm_tl", {31'd0, tl_out}, 32'd1);
    chk("enm_d", {28'd0, d_out}, 32'h1);
    th_in = 1'b1;
    step(3);
    enable = 1'b1;
    step(2);
    chk("enm_pops", pop_cnt - p0, 32'd0);
    run_packet(12, 1'b0, "enm_resend");

    // randomized packets with random events and lengths
    for (int r = 0; r < 8; r++) begin
      if (!ev_valid) begin
        ev_valid = 1'($urandom);
        ev_make  = 1'($urandom);
        ev_sc    = 8'($urandom);
      end
      run_packet($urandom_range(6, 13), 1'b1, $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/saturn_kbd_port.md
Name: saturn_kbd_port

Overview:
- Peripheral-side transmitter of the Saturn keyboard packet on the controller port, using the 3-wire TH/TR/TL handshake.
- Consumes the held-button nibbles, lock LEDs and the single-entry make/break event from the PS/2 keyboard front end.
- Drives the 12-nibble packet onto D3..D0, one nibble per TR edge from the SMPC.
- Pops the event only after its scancode has actually been delivered.

Parameters:
ACK_DLY, 8, clk cycles between a serviced TR edge (post-sync) and the TL toggle; must be >= 1
TMO_CYC, 65535, clk cycles without a TR edge inside a packet before the transfer is aborted
CNT_W, 16, width of the shared delay/timeout counter; must hold max(ACK_DLY, TMO_CYC)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous reset, active-low
enable  in  1  keyboard mode selected; low forces IDLE
nib_dpad  in  4  {Right,Left,Down,Up}, active-low
nib_start_abc  in  4  {Start,A,C,B}, active-low
nib_rxyz  in  4  {R,X,Y,Z}, active-low
nib_lxxx  in  4  {L,0,0,0}, active-low
led  in  3  {scroll,num,caps}
ev_valid  in  1  pending key event
ev_make  in  1  1 = make, 0 = break
ev_sc  in  8  Saturn scancode
ev_pop  out  1  one-cycle pulse, consumes event
th_in  in  1  select from SMPC, async, low = packet active
tr_in  in  1  request from SMPC, async, each edge = next nibble
tl_out  out  1  acknowledge
d_out  out  4  data nibble

Behaviour:
- Clock and reset: one clock (clk). reset_n is synchronous and active-low.
- Input synchronisers: th_in and tr_in each pass through a 2-FF synchroniser. A TR edge = synced value differs from its previous synced sample.
- Reset values: tl_out=1, d_out=4'h1, ev_pop=0, state IDLE, idx=0, snapshot cleared.
- IDLE: tl_out=1, d_out=4'h1 (ID/idle pattern).
  - On synced TH falling while enable=1: snapshot {ev_valid, ev_make, ev_sc}, go to READY.
- READY: count ACK_DLY cycles, then tl_out<=0, go to WAIT_TR, idx=0.
- WAIT_TR: on a TR edge, put nibble[idx] on d_out immediately, restart the counter, go to ACK.
  - No edge for TMO_CYC cycles -> ABORT.
- ACK: after ACK_DLY cycles, tl_out<=~tl_out, idx<=idx+1 (saturates at 12), return to WAIT_TR.
  - TR edges arriving during ACK are ignored; the host must not issue them.
- Packet nibbles, by index:
  - 0: 3
  - 1: 4
  - 2: nib_dpad
  - 3: nib_start_abc
  - 4: nib_rxyz
  - 5: nib_lxxx
  - 6: {0,caps,num,scroll}
  - 7: E if snapshot make, 7 if snapshot break, 6 if no event
  - 8: sc[7:4]
  - 9: sc[3:0] (scancode nibbles are 0 if no event)
  - 10: 0
  - 11: 1
  - idx >= 12: 0, still acknowledged.
- Buttons and LEDs are sampled live when their nibble is loaded; the event fields come from the snapshot only.
- ev_pop: one-cycle pulse in the cycle nibble 9 is acked (ACK exit with idx==9), and only if the snapshot held an event.
  - An aborted packet before that point does not pop, so the event is resent in the next packet.
- ABORT: tl_out=1, d_out=4'h1; wait for synced TH high, then IDLE.
- Synced TH rising in any state: go to IDLE next cycle, tl_out=1, d_out=4'h1, no pop, counter cleared.
  - If TH rises in the same cycle as the idx==9 ack completes, the pop wins and IDLE follows.
- enable low: forced to IDLE with idle outputs; no pops; th_in is ignored.
- Counter: a single down-counter, CNT_W bits, reloaded on each state entry; no wrap-around.
- Packet latency: TH fall to TL low = 2 (sync) + ACK_DLY cycles; TR edge to TL toggle = 2 + ACK_DLY cycles; TR edge to d_out valid = 3 cycles.

Decomposition:
- Shared package saturn_pad_pkg holds:
  - state enum (IDLE, READY, WAIT_TR, ACK, ABORT)
  - nibble constants ID0=3, ID1=4, MK=E, BRK=7, NONE=6, TAIL0=0, TAIL1=1, IDLE_D=1
  - packet length 12
- Sub-module saturn_sync2: 2-FF synchroniser with reset value 1. Instantiate it twice, for th_in and tr_in.

Test Plan:
- Idle, no event; TH low then 12 TR edges -> d_out sequence 3,4,F,F,F,8,0,6,0,0,0,1; TL toggles after each edge; ev_pop never asserted.
- ev_valid=1, make=1, sc=8'h1C, caps LED on -> nibble 6=4, nibble 7=E, nibble 8=1, nibble 9=C; ev_pop is exactly one pulse at the nibble-9 ack.
- Break event sc=8'h86 with Up held (nib_dpad=E) -> nibbles 2=E, 7=7, 8=8, 9=6; one pop.
- TH raised after nibble 5 with an event pending -> tl_out=1 and d_out=1 within 3 cycles; no pop; the next full packet delivers the same event and pops.
- TH low then no TR edges for TMO_CYC+1 cycles -> ABORT with tl_out=1; TH high then low restarts at nibble 0.
- reset_n low mid-packet, and separately enable low mid-packet -> idle outputs next cycle, no pop.
